rxsynccorr: RTL and testbench
=============================

# rxsynccorr

Parametrised receive sync-word correlator for the baseband receive path. It shifts the demodulated bit stream LSB-first into a SYNC_W-bit window on every 1 µs strobe. Each strobe it scores the window against the reference sync word as a bit-agreement count. It raises a single trigger per correlation window, either on the first threshold crossing or on the correlation peak. The trigger pulse drives the packet-header timing logic downstream.

## Interface
- SYNC_W, 64, sync word length in bits (8..64)
- CNT_W, 7, score width; must satisfy 2^CNT_W > SYNC_W
- PEAK_HOLD, 1, number of scored strobes without a new maximum before the peak is declared (1..15)

- clk_6M  in  1  system clock (6 MHz)
- rst  in  1  reset, synchronous, active-high; one clock, synchronous active-high reset
- p_1us  in  1  one-clock bit strobe; shift and score enable
- rxbit  in  1  demodulated bit, sampled when p_1us=1
- correWindow  in  1  correlation search window, level
- regi_correthreshold  in  CNT_W  minimum score for detection
- regi_peakmode  in  1  0 = trigger on first crossing, 1 = peak search
- ref_sync  in  SYNC_W  reference sync word, bit 0 transmitted first
- syncinword  out  SYNC_W  received bit window
- corr_score  out  CNT_W  registered agreement count
- pscorr_trgp  out  1  sync detect pulse, one clk_6M
- peak_score  out  CNT_W  score reported with the last trigger
- peak_lag  out  4  scored strobes between the peak and the trigger
- busy  out  1  FSM in SEARCH or PEAK

## Operation
- Shift register:
  - On p_1us, syncinword <= {rxbit, syncinword[SYNC_W-1:1]}.
  - Shifting is independent of correWindow.
- Fill counter:
  - Increments on p_1us and saturates at SYNC_W.
  - Scoring is enabled only when fill == SYNC_W.
  - Only rst clears it.
- Score:
  - corr_score = popcount(~(syncinword ^ ref_sync)), range 0..SYNC_W.
  - It is registered on the clock after p_1us.
  - score_vld is the internal one-cycle delayed copy of p_1us, gated by fill full.
- FSM states: IDLE, SEARCH, PEAK, DONE.
  - IDLE: correWindow=1 -> SEARCH.
  - SEARCH: correWindow=0 -> IDLE, no trigger; this has priority over a coincident score_vld.
  - SEARCH, on score_vld with corr_score >= regi_correthreshold:
    - If regi_peakmode=0: pulse the trigger, load peak_score=corr_score and peak_lag=0, go to DONE.
    - Otherwise: peak_score=corr_score, hold=0, go to PEAK.
  - PEAK, on score_vld:
    - If corr_score > peak_score: peak_score=corr_score, hold=0.
    - Otherwise: hold=hold+1.
    - When hold reaches PEAK_HOLD: pulse the trigger, peak_lag=PEAK_HOLD, go to DONE.
    - Equal scores do not restart the hold.
  - PEAK, correWindow=0: pulse the trigger with the current peak_score, peak_lag=hold, go to IDLE.
    - A coincident score_vld is evaluated first, so the peak can update in that same cycle.
  - DONE: correWindow=0 -> IDLE. There is at most one trigger per window.
- regi_peakmode and regi_correthreshold are sampled only on score_vld; changing them mid-window is legal.
- Threshold 0 triggers on the first scored strobe. A threshold above SYNC_W never triggers.
- The hold counter saturates and cannot wrap.
- busy = (state==SEARCH || state==PEAK).

## Timing
- Reset values:
  - syncinword=0, corr_score=0, peak_score=0, peak_lag=0, pscorr_trgp=0, busy=0.
  - Fill counter=0, hold=0, state=IDLE.
- rst applied mid-window returns everything to reset values on the next edge; no trigger is emitted.
- Latency: p_1us in cycle N shifts the bit at the end of N.
  - corr_score is valid in N+1.
  - pscorr_trgp is high in N+2 for exactly one cycle.
- peak_score and peak_lag update in the same cycle pscorr_trgp is high and hold until the next trigger.
- In peak mode, the trigger occurs PEAK_HOLD strobes after the peak strobe, plus the 2-cycle latency.
- A window-close trigger is issued 1 cycle after correWindow samples low.
- p_1us must be separated by at least 3 clk_6M cycles; the system provides 6.

## Test plan
- Reset mid-stream:
  - Stimulus: assert rst for 1 clock with syncinword non-zero and the FSM in PEAK.
  - Required: all outputs 0, state IDLE; no trigger follows when the window stays high with random bits.
- Immediate mode, exact match:
  - Stimulus: SYNC_W=64, threshold 60, ref_sync=64'h4E7A_3C91_D05B_28E6, send the word LSB-first inside the window.
  - Required: single pulse 2 clocks after the 64th strobe, peak_score=64, peak_lag=0.
- Fill gating:
  - Stimulus: threshold 0, window open from reset.
  - Required: no trigger before the 64th strobe; trigger on the 64th.
- Peak mode with 3 errors:
  - Stimulus: PEAK_HOLD=2, threshold 50, a 3-bit-error copy followed by random bits.
  - Required: trigger 2 strobes after the peak, peak_score=61, peak_lag=2, exactly one pulse in the window.
- Window close in PEAK:
  - Stimulus: drop correWindow one strobe after a crossing (score 55).
  - Required: pulse 1 cycle later, peak_score=55, peak_lag=1, state IDLE.
- Window close in SEARCH with coincident crossing:
  - Stimulus: the crossing score_vld and correWindow=0 land in the same cycle while in SEARCH.
  - Required: no pulse.

Source files
------------

// File: rtl/rxsynccorr_if.sv
// Bit-stream, configuration and detection signals between the receive
// front end (master) and the sync-word correlator (slave).
interface rxsynccorr_if #(
  parameter int SYNC_W = 64,
  parameter int CNT_W  = 7
);
  logic              p_1us;
  logic              rxbit;
  logic              correWindow;
  logic [CNT_W-1:0]  regi_correthreshold;
  logic              regi_peakmode;
  logic [SYNC_W-1:0] ref_sync;
  logic [SYNC_W-1:0] syncinword;
  logic [CNT_W-1:0]  corr_score;
  logic              pscorr_trgp;
  logic [CNT_W-1:0]  peak_score;
  logic [3:0]        peak_lag;
  logic              busy;

  modport master (
    output p_1us, rxbit, correWindow, regi_correthreshold, regi_peakmode, ref_sync,
    input  syncinword, corr_score, pscorr_trgp, peak_score, peak_lag, busy
  );

  modport slave (
    input  p_1us, rxbit, correWindow, regi_correthreshold, regi_peakmode, ref_sync,
    output syncinword, corr_score, pscorr_trgp, peak_score, peak_lag, busy
  );
endinterface

// File: rtl/rxsynccorr.sv
// Receive sync-word correlator: LSB-first bit window, agreement score and a
// single trigger per search window (first crossing or peak).
//   state  | meaning
//   IDLE   | window closed, waiting for correWindow
//   SEARCH | window open, waiting for a score at or above threshold
//   PEAK   | threshold crossed, tracking the maximum until it stops growing
//   DONE   | trigger issued, waiting for the window to close
module rxsynccorr #(
  parameter int SYNC_W    = 64,
  parameter int CNT_W     = 7,
  parameter int PEAK_HOLD = 1
) (
  input logic         clk_6M,
  input logic         rst,
  rxsynccorr_if.slave bus
);
  localparam int FILL_W = $clog2(SYNC_W + 1);

  typedef enum logic [1:0] {IDLE, SEARCH, PEAK, DONE} state_t;

  state_t            state_q;
  logic [SYNC_W-1:0] shift_q, shift_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [CNT_W-1:0]  score_q, score_d;
  logic              vld_q, vld_d;
  logic [CNT_W-1:0]  runmax_q, peak_q;
  logic [3:0]        hold_q, lag_q;
  logic              trg_q;
  logic [SYNC_W-1:0] agree;
  logic [CNT_W-1:0]  pop;
  logic              new_max;
  logic [CNT_W-1:0]  pk_cur;
  logic [3:0]        hd_cur;

  always_comb begin
    shift_d = bus.p_1us ? {bus.rxbit, shift_q[SYNC_W-1:1]} : shift_q;
    fill_d  = (bus.p_1us && fill_q != FILL_W'(SYNC_W)) ? fill_q + 1'b1 : fill_q;
    agree   = ~(shift_d ^ bus.ref_sync);
    pop     = '0;
    for (int i = 0; i < SYNC_W; i++) pop = pop + CNT_W'(agree[i]);
    score_d = bus.p_1us ? pop : score_q;
    // The strobe that completes the fill is already scored.
    vld_d   = bus.p_1us && (fill_d == FILL_W'(SYNC_W));
  end

  always_ff @(posedge clk_6M) begin
    if (rst) begin
      shift_q <= '0;
      fill_q  <= '0;
      score_q <= '0;
      vld_q   <= 1'b0;
    end else begin
      shift_q <= shift_d;
      fill_q  <= fill_d;
      score_q <= score_d;
      vld_q   <= vld_d;
    end
  end

  // Peak tracking with the current score folded in, so a closing window
  // still sees a coincident new maximum.
  always_comb begin
    new_max = vld_q && (score_q > runmax_q);
    pk_cur  = new_max ? score_q : runmax_q;
    if (new_max)                    hd_cur = 4'd0;
    else if (vld_q && hold_q != 4'hF) hd_cur = hold_q + 4'd1;
    else                            hd_cur = hold_q;
  end

  always_ff @(posedge clk_6M) begin
    if (rst) begin
      state_q  <= IDLE;
      runmax_q <= '0;
      hold_q   <= '0;
      peak_q   <= '0;
      lag_q    <= '0;
      trg_q    <= 1'b0;
    end else begin
      trg_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.correWindow) state_q <= SEARCH;
        SEARCH: begin
          if (!bus.correWindow) begin
            state_q <= IDLE;
          end else if (vld_q && score_q >= bus.regi_correthreshold) begin
            if (!bus.regi_peakmode) begin
              trg_q   <= 1'b1;
              peak_q  <= score_q;
              lag_q   <= 4'd0;
              state_q <= DONE;
            end else begin
              runmax_q <= score_q;
              hold_q   <= 4'd0;
              state_q  <= PEAK;
            end
          end
        end
        PEAK: begin
          runmax_q <= pk_cur;
          hold_q   <= hd_cur;
          if (vld_q && hd_cur == 4'(PEAK_HOLD)) begin
            trg_q   <= 1'b1;
            peak_q  <= pk_cur;
            lag_q   <= 4'(PEAK_HOLD);
            state_q <= bus.correWindow ? DONE : IDLE;
          end else if (!bus.correWindow) begin
            trg_q   <= 1'b1;
            peak_q  <= pk_cur;
            lag_q   <= hd_cur;
            state_q <= IDLE;
          end
        end
        DONE: if (!bus.correWindow) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.syncinword  = shift_q;
  assign bus.corr_score  = score_q;
  assign bus.pscorr_trgp = trg_q;
  assign bus.peak_score  = peak_q;
  assign bus.peak_lag    = lag_q;
  assign bus.busy        = (state_q == SEARCH) || (state_q == PEAK);
endmodule

// File: tb/tb_rxsynccorr.sv
// Directed bench for rxsynccorr (SYNC_W=64, PEAK_HOLD=2): immediate, peak,
// fill gating, window-close and reset scenarios with hand-computed results.
module tb_rxsynccorr;
  localparam int SYNC_W = 64;
  localparam int CNT_W  = 7;
  localparam logic [63:0] REF = 64'h4E7A_3C91_D05B_28E6;
  localparam logic [63:0] M3  = 64'h8000_0000_0400_0002;  // 3 flipped bits
  localparam logic [63:0] M9  = 64'h8101_0101_0101_0101;  // 9 flipped bits

  logic clk_6M = 1'b0;
  logic rst    = 1'b1;
  always #5 clk_6M = ~clk_6M;

  rxsynccorr_if #(.SYNC_W(SYNC_W), .CNT_W(CNT_W)) bus ();

  rxsynccorr #(.SYNC_W(SYNC_W), .CNT_W(CNT_W), .PEAK_HOLD(2)) dut (
    .clk_6M (clk_6M),
    .rst    (rst),
    .bus    (bus)
  );

  int n_chk = 0, n_fail = 0;
  int cyc = 0, trig_cnt = 0, trg_cyc = 0;
  int strobe_cyc = 0, peak_cyc = 0, close_cyc = 0, base = 0;

  always @(posedge clk_6M) cyc <= cyc + 1;
  always @(negedge clk_6M) if (bus.pscorr_trgp) begin
    trig_cnt = trig_cnt + 1;
    trg_cyc  = cyc;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk_6M);
    bus.p_1us  = 1'b1;
    bus.rxbit  = b;
    strobe_cyc = cyc;
    @(negedge clk_6M);
    bus.p_1us = 1'b0;
    repeat (4) @(negedge clk_6M);
  endtask

  task automatic send_word(input logic [63:0] w);
    for (int i = 0; i < 64; i++) send_bit(w[i]);
  endtask

  task automatic pulse_reset();
    @(negedge clk_6M) rst = 1'b1;
    @(negedge clk_6M) rst = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_word"},  bus.syncinword, 64'd0);
    chk({tag, "_score"}, 64'(bus.corr_score), 64'd0);
    chk({tag, "_peak"},  64'(bus.peak_score), 64'd0);
    chk({tag, "_lag"},   64'(bus.peak_lag), 64'd0);
    chk({tag, "_trg"},   64'(bus.pscorr_trgp), 64'd0);
    chk({tag, "_busy"},  64'(bus.busy), 64'd0);
  endtask

  initial begin
    bus.p_1us = 1'b0;
    bus.rxbit = 1'b0;
    bus.correWindow = 1'b0;
    bus.regi_correthreshold = '0;
    bus.regi_peakmode = 1'b0;
    bus.ref_sync = REF;
    @(negedge clk_6M);
    @(negedge clk_6M);
    chk_reset_vals("rst0");
    rst = 1'b0;

    // Immediate mode, exact match
    bus.regi_correthreshold = 7'd60;
    bus.regi_peakmode = 1'b0;
    bus.correWindow = 1'b1;
    base = trig_cnt;
    send_word(REF);
    chk("exact_cnt",   64'(trig_cnt - base), 64'd1);
    chk("exact_lat",   64'(trg_cyc - strobe_cyc), 64'd2);
    chk("exact_peak",  64'(bus.peak_score), 64'd64);
    chk("exact_lag",   64'(bus.peak_lag), 64'd0);
    chk("exact_score", 64'(bus.corr_score), 64'd64);
    chk("exact_word",  bus.syncinword, REF);
    chk("exact_busy",  64'(bus.busy), 64'd0);
    bus.correWindow = 1'b0;

    // Threshold above SYNC_W never fires
    pulse_reset();
    bus.regi_correthreshold = 7'd65;
    bus.correWindow = 1'b1;
    base = trig_cnt;
    send_word(REF);
    chk("thr65_cnt",  64'(trig_cnt - base), 64'd0);
    chk("thr65_busy", 64'(bus.busy), 64'd1);
    bus.correWindow = 1'b0;

    // Fill gating, threshold 0, window open from reset
    bus.regi_correthreshold = 7'd0;
    bus.correWindow = 1'b1;
    pulse_reset();
    base = trig_cnt;
    for (int i = 0; i < 63; i++) send_bit(1'($urandom_range(0, 1)));
    chk("fill63_cnt", 64'(trig_cnt - base), 64'd0);
    send_bit(1'($urandom_range(0, 1)));
    chk("fill64_cnt", 64'(trig_cnt - base), 64'd1);
    chk("fill64_lat", 64'(trg_cyc - strobe_cyc), 64'd2);
    bus.correWindow = 1'b0;

    // Peak mode, 3-bit-error copy then two more strobes
    pulse_reset();
    bus.regi_correthreshold = 7'd50;
    bus.regi_peakmode = 1'b1;
    bus.correWindow = 1'b1;
    base = trig_cnt;
    send_word(REF ^ M3);
    peak_cyc = strobe_cyc;
    chk("pk_busy",  64'(bus.busy), 64'd1);
    chk("pk_early", 64'(trig_cnt - base), 64'd0);
    send_bit(1'b1);
    send_bit(1'b0);
    chk("pk_cnt",  64'(trig_cnt - base), 64'd1);
    chk("pk_lat",  64'(trg_cyc - peak_cyc), 64'd14);
    chk("pk_peak", 64'(bus.peak_score), 64'd61);
    chk("pk_lag",  64'(bus.peak_lag), 64'd2);
    send_bit(1'b1);
    send_bit(1'b1);
    chk("pk_once", 64'(trig_cnt - base), 64'd1);
    bus.correWindow = 1'b0;

    // Window close while in PEAK, one strobe after a crossing at 55
    pulse_reset();
    bus.correWindow = 1'b1;
    base = trig_cnt;
    send_word(REF ^ M9);
    send_bit(1'b0);
    @(negedge clk_6M);
    bus.correWindow = 1'b0;
    close_cyc = cyc;
    repeat (3) @(negedge clk_6M);
    chk("cls_cnt",  64'(trig_cnt - base), 64'd1);
    chk("cls_lat",  64'(trg_cyc - close_cyc), 64'd1);
    chk("cls_peak", 64'(bus.peak_score), 64'd55);
    chk("cls_lag",  64'(bus.peak_lag), 64'd1);
    chk("cls_busy", 64'(bus.busy), 64'd0);

    // Window close in SEARCH coinciding with the crossing score
    pulse_reset();
    bus.regi_correthreshold = 7'd0;
    bus.regi_peakmode = 1'b0;
    bus.correWindow = 1'b1;
    base = trig_cnt;
    for (int i = 0; i < 63; i++) send_bit(REF[i]);
    @(negedge clk_6M);
    bus.p_1us = 1'b1;
    bus.rxbit = REF[63];
    @(negedge clk_6M);
    bus.p_1us = 1'b0;
    bus.correWindow = 1'b0;
    repeat (5) @(negedge clk_6M);
    chk("coin_cnt",  64'(trig_cnt - base), 64'd0);
    chk("coin_busy", 64'(bus.busy), 64'd0);

    // Reset mid-stream while in PEAK
    pulse_reset();
    bus.regi_correthreshold = 7'd50;
    bus.regi_peakmode = 1'b1;
    bus.correWindow = 1'b1;
    base = trig_cnt;
    send_word(REF ^ M3);
    chk("mid_busy_pre", 64'(bus.busy), 64'd1);
    chk("mid_word_pre", bus.syncinword, REF ^ M3);
    @(negedge clk_6M) rst = 1'b1;
    @(negedge clk_6M);
    chk_reset_vals("mid");
    rst = 1'b0;
    for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)));
    chk("mid_notrg", 64'(trig_cnt - base), 64'd0);
    bus.correWindow = 1'b0;
    repeat (3) @(negedge clk_6M);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
